// File: rtl/pipeline_staller.sv
// ----------------------------------------------------------------------------
// pipeline_staller
//
// Hazard and stall controller for a five-stage in-order pipeline. Each cycle
// it picks one stage-control pattern (Go / Stall / Bubble) for the PC, IF/ID,
// ID/EX, EX/MEM and MEM/WB registers from a fixed priority of hazards:
//   1. data memory busy        2. taken branch while a fetch is outstanding
//   3. taken branch            4. load-use hazard
//   5. fetch outstanding       6. nothing -> everything advances
// A two-state FSM (RUN / MEM_WAIT) tracks multi-cycle data accesses and
// declares a sticky timeout if an access never completes.
//
// Ports
//   dclk                      clock, rising edge
//   rst                       synchronous active-low reset
//   ex_is_load_i, ex_waddr_i  EX instruction is a load / its destination reg
//   id_re1_i, id_re2_i        ID instruction reads rs1 / rs2
//   id_raddr1_i, id_raddr2_i  ID source register addresses
//   br_taken_i                branch/jump resolved taken in EX
//   if_busy_i                 instruction fetch outstanding (level)
//   mem_req_i                 MEM starts a data access (one-cycle pulse)
//   mem_done_i                data access completes this cycle
//   stl_*_o                   stage control: 00 Go, 01 Stall, 10 Bubble
//   redirect_o                PC loads the branch target this cycle
//   mem_timeout_o             sticky data-access timeout flag
//   stall_cnt_o               saturating count of cycles with PC not Go
//   flush_cnt_o               saturating count of branch-flush cycles
//   state_dbg                 current FSM state (0 RUN, 1 MEM_WAIT)
//
// Handshake: mem_req_i is a request pulse sampled only in RUN; mem_done_i is
// a completion strobe that is honoured in the request cycle (zero-wait) or in
// any MEM_WAIT cycle. There is no back-pressure on either signal.
// ----------------------------------------------------------------------------
module pipeline_staller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        dclk,
    input  logic        rst,
    input  logic        ex_is_load_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic        id_re1_i,
    input  logic        id_re2_i,
    input  logic [4:0]  id_raddr1_i,
    input  logic [4:0]  id_raddr2_i,
    input  logic        br_taken_i,
    input  logic        if_busy_i,
    input  logic        mem_req_i,
    input  logic        mem_done_i,
    output logic [1:0]  stl_pc_o,
    output logic [1:0]  stl_ifid_o,
    output logic [1:0]  stl_idex_o,
    output logic [1:0]  stl_exmem_o,
    output logic [1:0]  stl_memwb_o,
    output logic        redirect_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o,
    output logic        state_dbg
);

    localparam logic [1:0] GO     = 2'b00;
    localparam logic [1:0] STALL  = 2'b01;
    localparam logic [1:0] BUBBLE = 2'b10;

    // wait_cnt only needs to hold 0 .. MEM_TIMEOUT-1.
    localparam int unsigned WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WCW-1:0]   wait_cnt, wait_cnt_nx;
    logic             timeout_nx;
    logic             load_use;
    logic             mem_busy;
    logic             flush_evt;

    // x0 is hard-wired zero, so a load targeting it can never feed ID.
    assign load_use = ex_is_load_i && (ex_waddr_i != 5'd0) &&
                      ((id_re1_i && (id_raddr1_i == ex_waddr_i)) ||
                       (id_re2_i && (id_raddr2_i == ex_waddr_i)));

    // Once the timeout flag is up, MEM never stalls the pipeline again.
    assign mem_busy = (((state == RUN) && mem_req_i) || (state == MEM_WAIT)) &&
                      !mem_done_i && !mem_timeout_o;

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge dclk) begin
        if (!rst) begin
            state         <= RUN;
            wait_cnt      <= '0;
            mem_timeout_o <= 1'b0;
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
        end else begin
            state         <= state_nx;
            wait_cnt      <= wait_cnt_nx;
            mem_timeout_o <= timeout_nx;
            if ((stl_pc_o != GO) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (flush_evt && (flush_cnt_o != 16'hFFFF)) begin
                flush_cnt_o <= flush_cnt_o + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and Mealy stage controls
    // ------------------------------------------------------------------
    always_comb begin
        stl_pc_o    = GO;
        stl_ifid_o  = GO;
        stl_idex_o  = GO;
        stl_exmem_o = GO;
        stl_memwb_o = GO;
        redirect_o  = 1'b0;
        flush_evt   = 1'b0;
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        timeout_nx  = mem_timeout_o;

        if (mem_busy) begin
            stl_pc_o    = STALL;
            stl_ifid_o  = STALL;
            stl_idex_o  = STALL;
            stl_exmem_o = STALL;
            stl_memwb_o = BUBBLE;
        end else if (br_taken_i && if_busy_i) begin
            // Hold the branch in EX; redirect once the fetch has drained.
            stl_pc_o    = STALL;
            stl_ifid_o  = STALL;
            stl_idex_o  = STALL;
            stl_exmem_o = BUBBLE;
        end else if (br_taken_i) begin
            stl_ifid_o  = BUBBLE;
            stl_idex_o  = BUBBLE;
            redirect_o  = 1'b1;
            flush_evt   = 1'b1;
        end else if (load_use) begin
            stl_pc_o    = STALL;
            stl_ifid_o  = STALL;
            stl_idex_o  = BUBBLE;
        end else if (if_busy_i) begin
            stl_pc_o    = STALL;
            stl_ifid_o  = BUBBLE;
        end

        case (state)
            RUN: begin
                // A request completing in the same cycle is zero-wait.
                if (mem_req_i && !mem_done_i && !mem_timeout_o) begin
                    state_nx    = MEM_WAIT;
                    wait_cnt_nx = '0;
                end
            end
            MEM_WAIT: begin
                // New requests are ignored here; only done/timeout leave.
                if (mem_done_i) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                    timeout_nx  = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + WCW'(1);
                end
            end
            default: begin
                state_nx    = RUN;
                wait_cnt_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_staller.sv
// ----------------------------------------------------------------------------
// tb_pipeline_staller
//
// Directed bench for pipeline_staller (MEM_TIMEOUT = 4). Inputs are driven
// 1 time unit after a rising edge; combinational stage controls are checked
// 1 unit later, and registered outputs 1 unit after the following edge.
// Stage patterns are written as {pc, ifid, idex, exmem, memwb}.
// ----------------------------------------------------------------------------
module tb_pipeline_staller;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] S = 2'b01;
    localparam logic [1:0] B = 2'b10;

    logic        dclk;
    logic        rst;
    logic        ex_is_load_i;
    logic [4:0]  ex_waddr_i;
    logic        id_re1_i;
    logic        id_re2_i;
    logic [4:0]  id_raddr1_i;
    logic [4:0]  id_raddr2_i;
    logic        br_taken_i;
    logic        if_busy_i;
    logic        mem_req_i;
    logic        mem_done_i;
    logic [1:0]  stl_pc_o;
    logic [1:0]  stl_ifid_o;
    logic [1:0]  stl_idex_o;
    logic [1:0]  stl_exmem_o;
    logic [1:0]  stl_memwb_o;
    logic        redirect_o;
    logic        mem_timeout_o;
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
    logic        state_dbg;

    int checks;
    int failures;

    pipeline_staller #(.MEM_TIMEOUT(4)) dut (
        .dclk          (dclk),
        .rst           (rst),
        .ex_is_load_i  (ex_is_load_i),
        .ex_waddr_i    (ex_waddr_i),
        .id_re1_i      (id_re1_i),
        .id_re2_i      (id_re2_i),
        .id_raddr1_i   (id_raddr1_i),
        .id_raddr2_i   (id_raddr2_i),
        .br_taken_i    (br_taken_i),
        .if_busy_i     (if_busy_i),
        .mem_req_i     (mem_req_i),
        .mem_done_i    (mem_done_i),
        .stl_pc_o      (stl_pc_o),
        .stl_ifid_o    (stl_ifid_o),
        .stl_idex_o    (stl_idex_o),
        .stl_exmem_o   (stl_exmem_o),
        .stl_memwb_o   (stl_memwb_o),
        .redirect_o    (redirect_o),
        .mem_timeout_o (mem_timeout_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
        .state_dbg     (state_dbg)
    );

    // Clock
    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    // Driver tasks
    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_is_load_i = 1'b0;
        ex_waddr_i   = 5'd0;
        id_re1_i     = 1'b0;
        id_re2_i     = 1'b0;
        id_raddr1_i  = 5'd0;
        id_raddr2_i  = 5'd0;
        br_taken_i   = 1'b0;
        if_busy_i    = 1'b0;
        mem_req_i    = 1'b0;
        mem_done_i   = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] waddr);
        ex_is_load_i = 1'b1;
        ex_waddr_i   = waddr;
        id_re1_i     = 1'b1;
        id_raddr1_i  = waddr;
    endtask

    // Checkers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stg(input string tag, input logic [9:0] exp, input logic exp_redir);
        #1;
        chk({tag, ".stages"}, {22'd0, stl_pc_o, stl_ifid_o, stl_idex_o, stl_exmem_o, stl_memwb_o},
            {22'd0, exp});
        chk({tag, ".redirect"}, {31'd0, redirect_o}, {31'd0, exp_redir});
    endtask

    task automatic chk_regs(input string tag, input logic exp_state, input logic exp_to,
                            input logic [31:0] exp_stall, input logic [15:0] exp_flush);
        chk({tag, ".state"}, {31'd0, state_dbg}, {31'd0, exp_state});
        chk({tag, ".timeout"}, {31'd0, mem_timeout_o}, {31'd0, exp_to});
        chk({tag, ".stall_cnt"}, stall_cnt_o, exp_stall);
        chk({tag, ".flush_cnt"}, {16'd0, flush_cnt_o}, {16'd0, exp_flush});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        rst = 1'b0;

        // Reset
        tick();
        tick();
        chk_regs("reset", 1'b0, 1'b0, 32'd0, 16'd0);
        chk_stg("reset", {G, G, G, G, G}, 1'b0);
        rst = 1'b1;

        // Idle
        tick();
        chk_stg("idle", {G, G, G, G, G}, 1'b0);
        tick();
        chk_regs("idle", 1'b0, 1'b0, 32'd0, 16'd0);

        // Load-use through rs1
        set_load_use(5'd5);
        chk_stg("lu_rs1", {S, S, B, G, G}, 1'b0);
        tick();
        chk_regs("lu_rs1", 1'b0, 1'b0, 32'd1, 16'd0);

        // Load-use through rs2 only
        id_re1_i    = 1'b0;
        id_raddr1_i = 5'd0;
        id_re2_i    = 1'b1;
        id_raddr2_i = 5'd5;
        chk_stg("lu_rs2", {S, S, B, G, G}, 1'b0);
        tick();
        chk_regs("lu_rs2", 1'b0, 1'b0, 32'd2, 16'd0);

        // Matching address but the port is not read
        clear_inputs();
        ex_is_load_i = 1'b1;
        ex_waddr_i   = 5'd5;
        id_raddr1_i  = 5'd5;
        chk_stg("lu_noread", {G, G, G, G, G}, 1'b0);

        // x0 never hazards
        clear_inputs();
        set_load_use(5'd0);
        chk_stg("lu_x0", {G, G, G, G, G}, 1'b0);
        tick();
        chk_regs("lu_x0", 1'b0, 1'b0, 32'd2, 16'd0);

        // Memory stall: done low for 3 cycles, then high
        clear_inputs();
        mem_req_i = 1'b1;
        chk_stg("mem_c0", {S, S, S, S, B}, 1'b0);
        tick();
        chk_regs("mem_c0", 1'b1, 1'b0, 32'd3, 16'd0);
        chk_stg("mem_c1", {S, S, S, S, B}, 1'b0);   // repeated request is ignored
        mem_req_i = 1'b0;
        tick();
        chk_stg("mem_c2", {S, S, S, S, B}, 1'b0);
        tick();
        chk_regs("mem_c2", 1'b1, 1'b0, 32'd5, 16'd0);
        mem_done_i = 1'b1;
        chk_stg("mem_done", {G, G, G, G, G}, 1'b0);
        tick();
        chk_regs("mem_done", 1'b0, 1'b0, 32'd5, 16'd0);

        // Zero-wait access
        mem_req_i  = 1'b1;
        mem_done_i = 1'b1;
        chk_stg("mem_zw", {G, G, G, G, G}, 1'b0);
        tick();
        chk_regs("mem_zw", 1'b0, 1'b0, 32'd5, 16'd0);

        // Branch while a fetch is outstanding
        clear_inputs();
        br_taken_i = 1'b1;
        if_busy_i  = 1'b1;
        chk_stg("br_busy0", {S, S, S, B, G}, 1'b0);
        tick();
        chk_stg("br_busy1", {S, S, S, B, G}, 1'b0);
        tick();
        if_busy_i = 1'b0;
        chk_stg("br_redir", {G, B, B, G, G}, 1'b1);
        tick();
        chk_regs("br_redir", 1'b0, 1'b0, 32'd7, 16'd1);

        // Fetch outstanding alone
        clear_inputs();
        if_busy_i = 1'b1;
        chk_stg("if_busy", {S, B, G, G, G}, 1'b0);
        tick();
        chk_regs("if_busy", 1'b0, 1'b0, 32'd8, 16'd1);

        // Priority: memory busy beats branch and load-use
        clear_inputs();
        set_load_use(5'd7);
        br_taken_i = 1'b1;
        mem_req_i  = 1'b1;
        chk_stg("prio_mem", {S, S, S, S, B}, 1'b0);
        tick();
        chk_regs("prio_mem", 1'b1, 1'b0, 32'd9, 16'd1);
        // Done in MEM_WAIT: lower rules apply the same cycle (branch wins)
        mem_req_i  = 1'b0;
        mem_done_i = 1'b1;
        chk_stg("prio_done", {G, B, B, G, G}, 1'b1);
        tick();
        chk_regs("prio_done", 1'b0, 1'b0, 32'd9, 16'd2);

        // Timeout: request then no done; four MEM_WAIT cycles
        clear_inputs();
        mem_req_i = 1'b1;
        tick();
        mem_req_i = 1'b0;
        chk_regs("to_enter", 1'b1, 1'b0, 32'd10, 16'd2);
        tick();
        tick();
        tick();
        chk_regs("to_w3", 1'b1, 1'b0, 32'd13, 16'd2);
        chk_stg("to_w4", {S, S, S, S, B}, 1'b0);
        tick();
        chk_regs("to_set", 1'b0, 1'b1, 32'd14, 16'd2);
        chk_stg("to_after", {G, G, G, G, G}, 1'b0);
        mem_req_i = 1'b1;
        chk_stg("to_masked", {G, G, G, G, G}, 1'b0);
        tick();
        chk_regs("to_masked", 1'b0, 1'b1, 32'd14, 16'd2);

        // Reset in the middle of MEM_WAIT
        clear_inputs();
        rst = 1'b0;
        tick();
        chk_regs("rst2", 1'b0, 1'b0, 32'd0, 16'd0);
        rst = 1'b1;
        if_busy_i = 1'b1;
        tick();                                   // stall_cnt -> 1
        clear_inputs();
        br_taken_i = 1'b1;
        tick();                                   // flush_cnt -> 1
        clear_inputs();
        mem_req_i = 1'b1;
        tick();
        mem_req_i = 1'b0;
        tick();
        chk_regs("pre_rst", 1'b1, 1'b0, 32'd3, 16'd1);
        rst = 1'b0;
        tick();
        chk_regs("rst_midwait", 1'b0, 1'b0, 32'd0, 16'd0);
        chk_stg("rst_midwait", {G, G, G, G, G}, 1'b0);
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
